scan_sel_gen: RTL and testbench
===============================

# scan_sel_gen

Programmable round-robin channel scanner that generates the 3-bit select code driving the 3-to-8 decoder's `de_in` input. It steps through the channels enabled in an 8-bit mask, holding each for a programmable dwell time. It flags every completed frame and counts them. It sits directly upstream of `decoder_3to8`, so each decoder output line is asserted in turn for a fixed number of cycles.

## Interface
- `DWELL_W`, default 8: width of the dwell-time input and of the internal dwell counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high; overrides every other input.
- `en`  in  1  scan enable; level-sensitive.
- `ch_mask`  in  8  channel enable mask; bit i set means channel i takes part in the scan.
- `dwell`  in  DWELL_W  hold time per channel, minus one (0 means 1 cycle per channel).
- `scan_sel`  out  3  current channel index; connects to the decoder's `de_in`.
- `sel_valid`  out  1  high while `scan_sel` is an active scan selection.
- `frame_done`  out  1  one-cycle pulse when the scan wraps back to the first enabled channel.
- `frame_cnt`  out  8  count of completed frames; wraps from 255 to 0.

## Operation
- State machine has two states, IDLE and SCAN.
- Reset values: state IDLE, `scan_sel`=0, `sel_valid`=0, `frame_done`=0, `frame_cnt`=0, dwell counter 0, latched dwell 0.
- IDLE to SCAN: when `en`=1 and `ch_mask`≠0, `scan_sel` takes the index of the lowest set bit of `ch_mask`, `sel_valid` goes to 1, and the dwell counter is cleared. `frame_done` stays 0 on this entry.
- IDLE with `en`=0 or `ch_mask`=0: remain in IDLE; `scan_sel` holds its last value and `sel_valid`=0.
- SCAN, dwell handling:
  - `dwell` is latched when each channel is entered.
  - The counter increments every cycle.
  - When counter equals the latched dwell, the block advances and the counter returns to 0.
- Advance rule:
  - The next channel is the first set bit of `ch_mask` searching upward from `scan_sel`+1, wrapping modulo 8. The search includes the current channel as the last candidate.
  - The new index is loaded and the new dwell is latched.
- Wrap detection: if the next index is ≤ the current index, `frame_done` pulses for 1 cycle and `frame_cnt` increments.
  - With a single enabled channel, the next index equals the current one, so `frame_done` pulses once per dwell period.
- Mask sampling: `ch_mask` is sampled only at the advance point. A mask change during a dwell does not shorten or cancel the current channel.
- Mask cleared: if `ch_mask`=0 at an advance point, go to IDLE with `sel_valid`=0 and no `frame_done`.
- `en` deasserted in SCAN: the next cycle is IDLE with `sel_valid`=0. `scan_sel` holds its value. The dwell counter is cleared and no `frame_done` is generated.
- Re-enable: the scan restarts from the lowest set bit; it does not resume.
- Reset during SCAN: the next cycle shows the reset values regardless of `en`.
- `frame_cnt` is cleared only by `rst`.

## Timing
- Start latency: `en` sampled high in IDLE gives `sel_valid`=1 with a valid `scan_sel` on the next cycle.
- Each selected channel is presented for exactly `dwell`+1 consecutive cycles, using the dwell latched at channel entry.
- The `frame_done` pulse coincides with the first cycle of the wrapped-to channel. `frame_cnt` shows the incremented value in that same cycle.
- Stop latency: `en` sampled low gives `sel_valid`=0 on the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- With `dwell`=0, `scan_sel` changes every cycle and a full-mask frame lasts 8 cycles.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `en`=1, `ch_mask`=0xFF. Required: `scan_sel`=0, `sel_valid`=0, `frame_done`=0, `frame_cnt`=0.
- **Full mask:** `ch_mask`=0xFF, `dwell`=0, `en`=1. Required: `scan_sel` sequence 0,1,…,7,0; `frame_done` high only on the return to 0; `frame_cnt`=1 there. The decoder output walks 0x01 to 0x80.
- **Sparse mask:** `ch_mask`=8'b1010_0100, `dwell`=2. Required: `scan_sel` sequence 2,2,2,5,5,5,7,7,7,2; `frame_done` high on the return to 2.
- **Single channel:** `ch_mask`=0x10, `dwell`=1. Required: `scan_sel`=4 constant, `sel_valid`=1, `frame_done` every 2nd cycle.
- **Dwell change:** `dwell`=3, `ch_mask`=0x03. Change `dwell` to 0 during channel 0. Required: channel 0 held 4 cycles, then channel 1 held 1 cycle. Also: clearing `ch_mask` mid-dwell still finishes the dwell, then `sel_valid`=0.
- **Stop and counter wrap:** drop `en` on channel 5 of a 0xFF scan. Required: `sel_valid`=0 next cycle and `scan_sel` holds 5; re-enable restarts at 0. Separately, run 256 frames; required: `frame_cnt` wraps from 255 to 0.

Source files
------------

// File: rtl/scan_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sel_gen
//  Description : Round-robin channel scanner. Walks the channels enabled in
//                an 8-bit mask, holding each for a programmable dwell, and
//                emits the 3-bit select code for a downstream 3-to-8 decoder.
//                Flags and counts completed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_sel_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         scan_sel,
    output logic               sel_valid,
    output logic               frame_done,
    output logic [7:0]         frame_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [2:0]         r_sel;
    logic [2:0]         w_sel_nx;
    logic               r_valid;
    logic               w_valid_nx;
    logic               r_done;
    logic               w_done_nx;
    logic [7:0]         r_fcnt;
    logic [7:0]         w_fcnt_nx;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nx;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nx;

    logic [2:0]         w_low;
    logic [2:0]         w_next;
    logic               w_wrap;

    // Index of the lowest set mask bit: the starting channel of a scan.
    always_comb begin
        w_low = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) w_low = 3'(i);
        end
    end

    // Next enabled channel searching upward from r_sel+1 modulo 8; the current
    // channel (offset 8) is the final candidate. Descending loop so the
    // smallest offset wins.
    always_comb begin
        logic [2:0] idx;
        w_next = r_sel;
        for (int k = 8; k >= 1; k--) begin
            idx = r_sel + 3'(k);
            if (ch_mask[idx]) w_next = idx;
        end
    end

    // A frame completes whenever the advance does not move strictly upward.
    assign w_wrap = (w_next <= r_sel);

    // Next-state and next-output logic for the IDLE/SCAN controller.
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_done_nx  = 1'b0;
        w_fcnt_nx  = r_fcnt;
        w_cnt_nx   = r_cnt;
        w_dwell_nx = r_dwell;
        case (r_state)
            S_IDLE: begin
                w_valid_nx = 1'b0;
                if (en && (ch_mask != 8'd0)) begin
                    w_state_nx = S_SCAN;
                    w_sel_nx   = w_low;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                    w_dwell_nx = dwell;
                end
            end
            S_SCAN: begin
                if (!en) begin
                    // Stop: select code is kept, only the valid flag drops.
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == r_dwell) begin
                    w_cnt_nx = '0;
                    if (ch_mask == 8'd0) begin
                        w_state_nx = S_IDLE;
                        w_valid_nx = 1'b0;
                    end else begin
                        w_sel_nx   = w_next;
                        w_dwell_nx = dwell;
                        if (w_wrap) begin
                            w_done_nx = 1'b1;
                            w_fcnt_nx = r_fcnt + 8'd1;
                        end
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= 8'd0;
            r_cnt   <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_fcnt  <= w_fcnt_nx;
            r_cnt   <= w_cnt_nx;
            r_dwell <= w_dwell_nx;
        end
    end

    assign scan_sel   = r_sel;
    assign sel_valid  = r_valid;
    assign frame_done = r_done;
    assign frame_cnt  = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_sel_gen
//  Description : Directed self-checking bench for scan_sel_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sel_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic [2:0] scan_sel;
    logic       sel_valid;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    scan_sel_gen #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .scan_sel   (scan_sel),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic ev,
                       input logic ed, input logic [7:0] ec);
        n_cmp++;
        assert (scan_sel === es && sel_valid === ev && frame_done === ed && frame_cnt === ec)
        else begin
            n_err++;
            $error("FAIL %s: got sel=%0d valid=%0b done=%0b cnt=%0d, expected sel=%0d valid=%0b done=%0b cnt=%0d",
                   tag, scan_sel, sel_valid, frame_done, frame_cnt, es, ev, ed, ec);
        end
    endtask

    int sp_seq [10] = '{2, 2, 2, 5, 5, 5, 7, 7, 7, 2};

    initial begin
        rst = 1'b1; en = 1'b1; ch_mask = 8'hFF; dwell = 8'd0;
        // Reset held two cycles with scan requested.
        nx(); nx();
        chk("reset", 3'd0, 1'b0, 1'b0, 8'd0);

        // Full mask, dwell 0: 0..7 then wrap to 0 with frame_done.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nx();
            chk("full_walk", 3'(i), 1'b1, 1'b0, 8'd0);
        end
        nx();
        chk("full_wrap", 3'd0, 1'b1, 1'b1, 8'd1);

        // Stop on channel 5, hold, then restart from lowest bit.
        for (int i = 1; i <= 5; i++) begin
            nx();
            chk("to_ch5", 3'(i), 1'b1, 1'b0, 8'd1);
        end
        en = 1'b0;
        nx();
        chk("stop", 3'd5, 1'b0, 1'b0, 8'd1);
        nx();
        chk("stop_hold", 3'd5, 1'b0, 1'b0, 8'd1);
        en = 1'b1;
        nx();
        chk("restart", 3'd0, 1'b1, 1'b0, 8'd1);

        // Sparse mask 1010_0100, dwell 2.
        en = 1'b0;
        nx();
        ch_mask = 8'b1010_0100; dwell = 8'd2; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nx();
            chk("sparse", 3'(sp_seq[i]), 1'b1, (i == 9), (i == 9) ? 8'd2 : 8'd1);
        end

        // Single channel 4, dwell 1: frame_done every second cycle.
        en = 1'b0;
        nx();
        ch_mask = 8'h10; dwell = 8'd1; en = 1'b1;
        nx();
        chk("single_0", 3'd4, 1'b1, 1'b0, 8'd2);
        nx();
        chk("single_1", 3'd4, 1'b1, 1'b0, 8'd2);
        nx();
        chk("single_2", 3'd4, 1'b1, 1'b1, 8'd3);
        nx();
        chk("single_3", 3'd4, 1'b1, 1'b0, 8'd3);
        nx();
        chk("single_4", 3'd4, 1'b1, 1'b1, 8'd4);

        // Dwell change mid-channel: ch0 held 4 cycles, ch1 held 1 cycle.
        en = 1'b0;
        nx();
        ch_mask = 8'h03; dwell = 8'd3; en = 1'b1;
        nx();
        chk("dw_ch0_0", 3'd0, 1'b1, 1'b0, 8'd4);
        dwell = 8'd0;
        for (int i = 1; i < 4; i++) begin
            nx();
            chk("dw_ch0", 3'd0, 1'b1, 1'b0, 8'd4);
        end
        nx();
        chk("dw_ch1", 3'd1, 1'b1, 1'b0, 8'd4);
        dwell = 8'd3;
        nx();
        chk("dw_wrap", 3'd0, 1'b1, 1'b1, 8'd5);
        // Mask cleared mid-dwell: channel 0 still completes its 4 cycles.
        ch_mask = 8'h00;
        for (int i = 0; i < 3; i++) begin
            nx();
            chk("clr_finish", 3'd0, 1'b1, 1'b0, 8'd5);
        end
        nx();
        chk("clr_idle", 3'd0, 1'b0, 1'b0, 8'd5);

        // Frame counter wrap: full mask, dwell 0, 8 cycles per frame.
        ch_mask = 8'hFF; dwell = 8'd0;
        nx();
        chk("wrap_start", 3'd0, 1'b1, 1'b0, 8'd5);
        repeat (250 * 8) nx();
        chk("cnt_255", 3'd0, 1'b1, 1'b1, 8'd255);
        repeat (8) nx();
        chk("cnt_0", 3'd0, 1'b1, 1'b1, 8'd0);
        nx();
        chk("after_wrap", 3'd1, 1'b1, 1'b0, 8'd0);

        // Reset during scan.
        rst = 1'b1;
        nx();
        chk("rst_scan", 3'd0, 1'b0, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
